// File: rtl/spike_rate_decoder.sv
// Spike-train to firing-rate decoder: counts spikes over a 2^WINDOW_LOG2 enabled-cycle window.
// Optional inter-spike-interval output is built when SPIKE_ISI_EN is defined.
module spike_rate_decoder #(
    parameter int WINDOW_LOG2 = 8,
    parameter int COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               clear,
    input  logic               spike,
    output logic [COUNT_W-1:0] rate,
    output logic               rate_valid,
    output logic               rate_sat,
    output logic [COUNT_W-1:0] isi,
    output logic               isi_valid
);

    logic [WINDOW_LOG2-1:0] r_win_cnt;
    logic [COUNT_W-1:0]     r_spk_cnt;
    logic                   r_sat_acc;
    logic [COUNT_W-1:0]     r_rate;
    logic                   r_rate_valid;
    logic                   r_rate_sat;

    logic                   w_win_last;
    logic                   w_spk_max;
    logic [COUNT_W-1:0]     w_rate_next;
    logic                   w_sat_next;

    assign w_win_last  = &r_win_cnt;
    assign w_spk_max   = &r_spk_cnt;
    // A spike on the closing cycle still belongs to the closing window.
    assign w_rate_next = w_spk_max ? {COUNT_W{1'b1}} : (r_spk_cnt + COUNT_W'(spike));
    assign w_sat_next  = r_sat_acc | (spike & w_spk_max);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_sat_acc    <= 1'b0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
            r_rate_sat   <= 1'b0;
        end else if (clear) begin
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_sat_acc    <= 1'b0;
            r_rate_valid <= 1'b0;
        end else if (ena) begin
            r_win_cnt <= r_win_cnt + WINDOW_LOG2'(1);
            if (w_win_last) begin
                r_rate       <= w_rate_next;
                r_rate_sat   <= w_sat_next;
                r_rate_valid <= 1'b1;
                r_spk_cnt    <= '0;
                r_sat_acc    <= 1'b0;
            end else begin
                r_rate_valid <= 1'b0;
                if (spike) begin
                    if (w_spk_max) begin
                        r_sat_acc <= 1'b1;
                    end else begin
                        r_spk_cnt <= r_spk_cnt + COUNT_W'(1);
                    end
                end
            end
        end else begin
            r_rate_valid <= 1'b0;
        end
    end

    assign rate       = r_rate;
    assign rate_valid = r_rate_valid;
    assign rate_sat   = r_rate_sat;

`ifdef SPIKE_ISI_EN
    logic [COUNT_W-1:0] r_isi_cnt;
    logic [COUNT_W-1:0] r_isi;
    logic               r_isi_valid;
    logic               w_isi_max;

    assign w_isi_max = &r_isi_cnt;

    // The interval includes the spike cycle itself, hence the +1 on report.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_isi_cnt   <= '0;
            r_isi       <= '0;
            r_isi_valid <= 1'b0;
        end else if (clear) begin
            r_isi_cnt   <= '0;
            r_isi_valid <= 1'b0;
        end else if (ena) begin
            if (spike) begin
                r_isi       <= w_isi_max ? {COUNT_W{1'b1}} : (r_isi_cnt + COUNT_W'(1));
                r_isi_valid <= 1'b1;
                r_isi_cnt   <= '0;
            end else begin
                r_isi_valid <= 1'b0;
                if (!w_isi_max) begin
                    r_isi_cnt <= r_isi_cnt + COUNT_W'(1);
                end
            end
        end else begin
            r_isi_valid <= 1'b0;
        end
    end

    assign isi       = r_isi;
    assign isi_valid = r_isi_valid;
`else
    assign isi       = '0;
    assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: a 16-cycle-window instance and a default 256-cycle instance
// share one stimulus stream; a window-total model feeds expected-result queues.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       clear = 1'b0;
    logic       spike = 1'b0;

    logic [7:0] rate0, rate1, isi0, isi1;
    logic       rate_valid0, rate_valid1, rate_sat0, rate_sat1, isi_valid0, isi_valid1;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;

    // Packed as {edge number[15:0], sat, value[7:0]}
    logic [24:0] rq0[$];
    logic [24:0] rq1[$];
    logic [24:0] isq[$];
    logic [24:0] e;

    int wl[2] = '{4, 8};
    int m_win[2], m_tot[2], m_rate[2], m_sat[2], m_rv[2];
    int m_isi_cnt, m_isi, m_isiv;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW_LOG2(4), .COUNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .spike(spike),
        .rate(rate0), .rate_valid(rate_valid0), .rate_sat(rate_sat0),
        .isi(isi0), .isi_valid(isi_valid0)
    );

    spike_rate_decoder dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .spike(spike),
        .rate(rate1), .rate_valid(rate_valid1), .rate_sat(rate_sat1),
        .isi(isi1), .isi_valid(isi_valid1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    // Reference model: rate is the window's spike total clipped to 255, sat when total > 255.
    task automatic model_edge();
        cyc++;
        for (int d = 0; d < 2; d++) begin
            m_rv[d] = 0;
            if (!rst_n) begin
                m_win[d] = 0; m_tot[d] = 0; m_rate[d] = 0; m_sat[d] = 0;
            end else if (clear) begin
                m_win[d] = 0; m_tot[d] = 0;
            end else if (ena) begin
                m_tot[d] += int'(spike);
                if (m_win[d] == (1 << wl[d]) - 1) begin
                    m_rate[d] = (m_tot[d] > 255) ? 255 : m_tot[d];
                    m_sat[d]  = (m_tot[d] > 255) ? 1 : 0;
                    m_rv[d]   = 1;
                    e = {16'(cyc), 1'(m_sat[d]), 8'(m_rate[d])};
                    if (d == 0) rq0.push_back(e);
                    else        rq1.push_back(e);
                    m_win[d] = 0;
                    m_tot[d] = 0;
                end else begin
                    m_win[d]++;
                end
            end
        end
        m_isiv = 0;
`ifdef SPIKE_ISI_EN
        if (!rst_n) begin
            m_isi_cnt = 0; m_isi = 0;
        end else if (clear) begin
            m_isi_cnt = 0;
        end else if (ena) begin
            if (spike) begin
                m_isi  = (m_isi_cnt + 1 > 255) ? 255 : m_isi_cnt + 1;
                m_isiv = 1;
                isq.push_back({16'(cyc), 1'b0, 8'(m_isi)});
                m_isi_cnt = 0;
            end else begin
                m_isi_cnt++;
            end
        end
`endif
    endtask

    task automatic step(input logic e_in, input logic c_in, input logic s_in);
        ena   = e_in;
        clear = c_in;
        spike = s_in;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic window16(input logic [15:0] pat);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, pat[i]);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("rate0", rate0, m_rate[0]);
            check("rate_sat0", rate_sat0, m_sat[0]);
            check("rate_valid0", rate_valid0, m_rv[0]);
            check("rate1", rate1, m_rate[1]);
            check("rate_sat1", rate_sat1, m_sat[1]);
            check("rate_valid1", rate_valid1, m_rv[1]);
            check("isi0", isi0, m_isi);
            check("isi1", isi1, m_isi);
            check("isi_valid0", isi_valid0, m_isiv);
            check("isi_valid1", isi_valid1, m_isiv);
            if (rate_valid0) begin
                if (rq0.size() == 0) check("rv0_unexpected", rate_valid0, 0);
                else check("win0", {16'(cyc), rate_sat0, rate0}, rq0.pop_front());
            end
            if (rate_valid1) begin
                if (rq1.size() == 0) check("rv1_unexpected", rate_valid1, 0);
                else check("win1", {16'(cyc), rate_sat1, rate1}, rq1.pop_front());
            end
            if (isi_valid0) begin
                if (isq.size() == 0) check("isi_unexpected", isi_valid0, 0);
                else check("isi_ev", {16'(cyc), 1'b0, isi0}, isq.pop_front());
            end
        end
    end

    initial begin
        // Reset with spike high: reset outranks everything
        do_reset();
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Spikes at window cycles 0,3,7,15 -> rate 4, then an idle window -> rate 0
        do_reset();
        window16(16'b1000_0000_1000_1001);
        window16(16'h0000);

        // ISI: spikes at enabled cycles 5 and 12 after reset
        do_reset();
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, (i == 5) || (i == 12));

        // Continuous spikes for a full default window, then an idle one
        do_reset();
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b0);

        // Exactly 255 spikes in a default window: full scale without saturation
        do_reset();
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, i != 255);

        // Pause for 10 cycles mid-window with spike toggling
        do_reset();
        for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, i[0]);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, i[0]);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b1);

        // Rate 4 held, 3 spikes then clear at win_cnt 9 (spike discarded), then a fresh window
        do_reset();
        window16(16'b1000_0000_1000_1001);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, (i % 3) == 0);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));

        // Reset mid-window with rate 4 held, then a full window after reset
        do_reset();
        window16(16'b1000_0000_1000_1001);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));

        // Random traffic with occasional pauses and clears
        for (int i = 0; i < 1200; i++) begin
            step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 3) != 0));
        end

        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rq0_left", rq0.size(), 0);
        check("rq1_left", rq1.size(), 0);
        check("isq_left", isq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
